vc_mem_net_adapter: RTL and testbench

Requester-side bridge between a memory-request port and the on-chip network: it wraps each outgoing memory request in a network message addressed to a memory bank node and strips the header off returning response messages. It is the counterpart of the memory-side network-memory adapter, and sits between a processor/cache port and a network terminal. Responses are delivered to the requester in request order.

---
 rtl/vc_mem_net_adapter_if.sv | 11 +
 rtl/vc_mem_net_adapter.sv | 108 ++++++++++
 tb/tb_vc_mem_net_adapter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_mem_net_adapter_if.sv
// rtl/vc_mem_net_adapter_if.sv - valid/ready message channel used on every adapter port
interface vc_mem_net_adapter_if #(
    parameter int p_msg_sz = 1
);
    logic [p_msg_sz-1:0] msg;
    logic                val;
    logic                rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/vc_mem_net_adapter.sv
// rtl/vc_mem_net_adapter.sv - requester-side bridge wrapping mem requests into network messages
// Responses are kept in order by only admitting requests to one bank at a time.
module vc_mem_net_adapter #(
    parameter int p_num_nodes    = 4,
    parameter int p_addr_sz      = 16,
    parameter int p_data_sz      = 32,
    parameter int p_node_id      = 0,
    parameter int p_bank_lsb     = 2,
    parameter int p_max_inflight = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vc_mem_net_adapter_if.slave  memreq,
    vc_mem_net_adapter_if.master netout,
    vc_mem_net_adapter_if.slave  netin,
    vc_mem_net_adapter_if.master memresp,
    output logic                 err
);
    localparam int c_srcdest_sz = $clog2(p_num_nodes);
    localparam int c_len_sz     = $clog2(p_data_sz / 8);
    localparam int c_req_sz     = 1 + p_addr_sz + c_len_sz + p_data_sz;
    localparam int c_resp_sz    = 1 + c_len_sz + p_data_sz;
    localparam int c_netreq_sz  = c_req_sz + 2 * c_srcdest_sz;
    localparam int c_cnt_sz     = $clog2(p_max_inflight + 1);
    localparam logic [c_cnt_sz-1:0]     c_max = c_cnt_sz'(p_max_inflight);
    localparam logic [c_srcdest_sz-1:0] c_src = c_srcdest_sz'(p_node_id);

    logic [c_netreq_sz-1:0]  req_msg_q, req_msg_d;
    logic                    req_full_q, req_full_d;
    logic [c_resp_sz-1:0]    resp_msg_q, resp_msg_d;
    logic                    resp_full_q, resp_full_d;
    logic [c_cnt_sz-1:0]     cnt_q, cnt_d;
    logic [c_srcdest_sz-1:0] cur_dest_q, cur_dest_d;
    logic                    err_q, err_d;

    logic [c_srcdest_sz-1:0] req_dest, resp_src;
    logic req_fire, netout_fire, netin_fire, memresp_fire, dest_ok, cnt_inc, cnt_dec;
    logic unused_netin_dest;

    assign req_dest = memreq.msg[c_len_sz + p_data_sz + p_bank_lsb +: c_srcdest_sz];
    assign resp_src = netin.msg[c_resp_sz +: c_srcdest_sz];
    assign unused_netin_dest = ^netin.msg[c_resp_sz + c_srcdest_sz +: c_srcdest_sz];

    assign dest_ok      = (cnt_q == '0) || (req_dest == cur_dest_q);
    assign memreq.rdy   = ~reset & (~req_full_q | netout.rdy) & (cnt_q < c_max) & dest_ok;
    assign netin.rdy    = ~reset & (~resp_full_q | memresp.rdy);
    assign req_fire     = memreq.val & memreq.rdy;
    assign netout_fire  = req_full_q & netout.rdy;
    assign netin_fire   = netin.val & netin.rdy;
    assign memresp_fire = resp_full_q & memresp.rdy;

    // An unsolicited response can be delivered with cnt at zero; never let it wrap.
    assign cnt_inc = req_fire;
    assign cnt_dec = memresp_fire & (cnt_q != '0);

    always_comb begin
        req_msg_d   = req_msg_q;
        req_full_d  = req_full_q;
        resp_msg_d  = resp_msg_q;
        resp_full_d = resp_full_q;
        cnt_d       = cnt_q;
        cur_dest_d  = cur_dest_q;
        err_d       = err_q;

        if (netout_fire) req_full_d = 1'b0;
        if (req_fire) begin
            req_msg_d  = {req_dest, c_src, memreq.msg};
            req_full_d = 1'b1;
            cur_dest_d = req_dest;
        end

        if (memresp_fire) resp_full_d = 1'b0;
        if (netin_fire) begin
            resp_msg_d  = netin.msg[c_resp_sz-1:0];
            resp_full_d = 1'b1;
            if ((resp_src != cur_dest_q) || (cnt_q == '0)) err_d = 1'b1;
        end

        if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + c_cnt_sz'(1);
        else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - c_cnt_sz'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_msg_q   <= '0;
            req_full_q  <= 1'b0;
            resp_msg_q  <= '0;
            resp_full_q <= 1'b0;
            cnt_q       <= '0;
            cur_dest_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            req_msg_q   <= req_msg_d;
            req_full_q  <= req_full_d;
            resp_msg_q  <= resp_msg_d;
            resp_full_q <= resp_full_d;
            cnt_q       <= cnt_d;
            cur_dest_q  <= cur_dest_d;
            err_q       <= err_d;
        end
    end

    assign netout.msg  = req_msg_q;
    assign netout.val  = req_full_q;
    assign memresp.msg = resp_msg_q;
    assign memresp.val = resp_full_q;
    assign err         = err_q;
endmodule

// File: tb/tb_vc_mem_net_adapter.sv
// tb/tb_vc_mem_net_adapter.sv - directed and randomized checks against a queue-based reference model
`timescale 1ns/1ps
module tb_vc_mem_net_adapter;
    localparam int NODE     = 1;
    localparam int MAXQ     = 4;
    localparam int REQ_SZ   = 51;
    localparam int RESP_SZ  = 35;
    localparam int NREQ_SZ  = 55;
    localparam int NRESP_SZ = 39;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err;
    always #5 clk = ~clk;

    vc_mem_net_adapter_if #(.p_msg_sz(REQ_SZ))   memreq_if ();
    vc_mem_net_adapter_if #(.p_msg_sz(NREQ_SZ))  netout_if ();
    vc_mem_net_adapter_if #(.p_msg_sz(NRESP_SZ)) netin_if ();
    vc_mem_net_adapter_if #(.p_msg_sz(RESP_SZ))  memresp_if ();

    vc_mem_net_adapter #(
        .p_num_nodes(4), .p_addr_sz(16), .p_data_sz(32), .p_node_id(NODE),
        .p_bank_lsb(2), .p_max_inflight(MAXQ)
    ) dut (
        .clk(clk), .reset(reset), .memreq(memreq_if), .netout(netout_if),
        .netin(netin_if), .memresp(memresp_if), .err(err)
    );

    logic [NREQ_SZ-1:0] net_q[$];
    logic [RESP_SZ-1:0] resp_q[$];
    int                 outst[$];
    int                 cur_dest = 0;
    bit                 exp_err = 0;
    logic [NREQ_SZ-1:0] mem_q[$];
    logic [NREQ_SZ-1:0] dut_nout[$];
    logic [REQ_SZ-1:0]  reqs[$];
    logic [RESP_SZ-1:0] got[$];
    bit                 auto_resp = 0, netin_auto = 0, rand_rdy = 0;
    int                 resp_pct = 100;
    int                 data_ctr = 0;
    int                 errors = 0, checks = 0;

    function automatic logic [REQ_SZ-1:0] mk_req(bit wr, int addr, logic [31:0] data);
        logic [15:0] a;
        a = addr[15:0];
        return {wr, a, 2'b00, data};
    endfunction

    function automatic int bank(logic [REQ_SZ-1:0] m);
        int addr;
        addr = int'(m[49:34]);
        return (addr / 4) % 4;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit e_req_rdy, e_nin_rdy, e_nout_val, e_resp_val, rf, nof, nif, mrf;
        int d;
        logic [REQ_SZ-1:0]   rmsg;
        logic [NRESP_SZ-1:0] nmsg;
        logic [NREQ_SZ-1:0]  m;
        #2;
        rmsg = memreq_if.msg;
        nmsg = netin_if.msg;
        d = bank(rmsg);
        e_nout_val = net_q.size() > 0;
        e_resp_val = resp_q.size() > 0;
        e_req_rdy  = !reset && (!e_nout_val || netout_if.rdy) && outst.size() < MAXQ
                     && (outst.size() == 0 || d == cur_dest);
        e_nin_rdy  = !reset && (!e_resp_val || memresp_if.rdy);
        chk("memreq_rdy", memreq_if.rdy, e_req_rdy);
        chk("netin_rdy", netin_if.rdy, e_nin_rdy);
        chk("netout_val", netout_if.val, e_nout_val);
        chk("memresp_val", memresp_if.val, e_resp_val);
        chk("err", err, exp_err);
        if (e_nout_val) chk("netout_msg", netout_if.msg, net_q[0]);
        if (e_resp_val) chk("memresp_msg", memresp_if.msg, resp_q[0]);
        rf  = memreq_if.val && e_req_rdy;
        nof = e_nout_val && netout_if.rdy;
        nif = netin_if.val && e_nin_rdy;
        mrf = e_resp_val && memresp_if.rdy;
        if (mrf && !reset) got.push_back(memresp_if.msg);
        if (nof && !reset) dut_nout.push_back(netout_if.msg);
        @(posedge clk);
        if (reset) begin
            net_q.delete(); resp_q.delete(); outst.delete();
            cur_dest = 0; exp_err = 0;
        end else begin
            if (nif && (outst.size() == 0 || int'(nmsg[36:35]) != cur_dest)) exp_err = 1;
            if (mrf) begin
                resp_q.delete(0);
                if (outst.size() > 0) outst.delete(0);
            end
            if (nof) begin
                mem_q.push_back(net_q[0]);
                net_q.delete(0);
            end
            if (rf) begin
                net_q.push_back({2'(d), 2'(NODE), rmsg});
                outst.push_back(d);
                cur_dest = d;
            end
            if (nif) begin
                resp_q.push_back(nmsg[34:0]);
                if (netin_auto) mem_q.delete(0);
            end
        end
        #1;
        if (rf) memreq_if.val = 1'b0;
        if (nif) netin_if.val = 1'b0;
        if (!memreq_if.val && reqs.size() > 0 && !reset) begin
            memreq_if.msg = reqs.pop_front();
            memreq_if.val = 1'b1;
        end
        if (auto_resp && !netin_if.val && mem_q.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
            m = mem_q[0];
            netin_if.msg = {2'(NODE), m[54:53], m[50], 2'b00, 32'(data_ctr)};
            netin_if.val = 1'b1;
            netin_auto = 1;
            data_ctr++;
        end
        if (rand_rdy) begin
            netout_if.rdy  = $urandom_range(0, 3) != 0;
            memresp_if.rdy = $urandom_range(0, 3) != 0;
        end
    endtask

    function automatic bit idle();
        return reqs.size() == 0 && !memreq_if.val && net_q.size() == 0 && mem_q.size() == 0
               && !netin_if.val && resp_q.size() == 0;
    endfunction

    task automatic run_until_idle(string tag, int budget);
        int n = 0;
        while (n < budget && !idle()) begin
            tick();
            n++;
        end
        chk(tag, n < budget, 1'b1);
    endtask

    task automatic run_until_mem(string tag, int cnt, int budget);
        int n = 0;
        while (n < budget && mem_q.size() < cnt) begin
            tick();
            n++;
        end
        chk(tag, n < budget, 1'b1);
    endtask

    task automatic inject(logic [1:0] src, logic [31:0] data);
        int n = 0;
        netin_auto = 0;
        netin_if.msg = {2'(NODE), src, 1'b0, 2'b00, data};
        netin_if.val = 1'b1;
        while (n < 50 && netin_if.val) begin
            tick();
            n++;
        end
        chk("inject_timeout", n < 50, 1'b1);
    endtask

    initial begin
        memreq_if.val = 1'b0; memreq_if.msg = '0;
        netout_if.rdy = 1'b0; memresp_if.rdy = 1'b0;
        netin_if.val = 1'b0;  netin_if.msg = '0;
        @(posedge clk); #1;
        tick();
        chk("reset_memreq_rdy", memreq_if.rdy, 1'b0);
        chk("reset_err", err, 1'b0);
        reset = 1'b0;
        netout_if.rdy = 1'b1; memresp_if.rdy = 1'b1;

        // single write to bank 2
        reqs.push_back(mk_req(1'b1, 16'h0008, 32'h0a0b0c0d));
        run_until_mem("t1_issue", 1, 20);
        chk("t1_netout", dut_nout[$], {2'd2, 2'd1, mk_req(1'b1, 16'h0008, 32'h0a0b0c0d)});
        got.delete();
        auto_resp = 1;
        run_until_idle("t1_idle", 30);
        chk("t1_resp_count", got.size(), 1);
        chk("t1_resp_type", got[0][34], 1'b1);
        chk("t1_err", err, 1'b0);

        // eight back-to-back reads, looped-back data 0..7
        got.delete(); data_ctr = 0;
        for (int i = 0; i < 8; i++) reqs.push_back(mk_req(1'b0, 0, 32'h0));
        run_until_idle("t2_idle", 60);
        chk("t2_resp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_data", got[i][31:0], 32'(i));

        // bank switch held off while the first response is withheld
        auto_resp = 0; dut_nout.delete();
        reqs.push_back(mk_req(1'b0, 16'h0004, 32'h0));
        reqs.push_back(mk_req(1'b0, 16'h0008, 32'h0));
        repeat (12) tick();
        chk("t3_stall_rdy", memreq_if.rdy, 1'b0);
        chk("t3_stall_count", dut_nout.size(), 1);
        auto_resp = 1;
        run_until_idle("t3_idle", 40);
        chk("t3_second_dest", dut_nout[$][54:53], 2'd2);

        // backpressure on both paths
        netout_if.rdy = 1'b0; got.delete();
        reqs.push_back(mk_req(1'b0, 16'h0010, 32'h0));
        reqs.push_back(mk_req(1'b1, 16'h0010, 32'h55aa55aa));
        repeat (7) tick();
        chk("t4_memreq_rdy", memreq_if.rdy, 1'b0);
        netout_if.rdy = 1'b1; memresp_if.rdy = 1'b0;
        repeat (6) tick();
        chk("t4_netin_rdy", netin_if.rdy, 1'b0);
        memresp_if.rdy = 1'b1;
        run_until_idle("t4_idle", 40);
        chk("t4_resp_count", got.size(), 2);

        // random traffic with random backpressure
        got.delete(); rand_rdy = 1; resp_pct = 60;
        for (int i = 0; i < 40; i++)
            reqs.push_back(mk_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), $urandom));
        run_until_idle("t5_idle", 2000);
        rand_rdy = 0; resp_pct = 100;
        netout_if.rdy = 1'b1; memresp_if.rdy = 1'b1;
        tick();
        chk("t5_resp_count", got.size(), 40);

        // wrong-source response, then response with nothing outstanding
        auto_resp = 0; got.delete();
        reqs.push_back(mk_req(1'b0, 16'h0004, 32'h0));
        run_until_mem("t6_issue", 1, 20);
        mem_q.delete();
        inject(2'd3, 32'hdead0001);
        chk("t6_err_first", err, 1'b1);
        repeat (2) tick();
        inject(2'd1, 32'hdead0002);
        repeat (2) tick();
        chk("t6_err_hold", err, 1'b1);
        chk("t6_resp_count", got.size(), 2);
        chk("t6_resp_data", got[$][31:0], 32'hdead0002);

        // reset with two outstanding and both buffers full
        auto_resp = 1; memresp_if.rdy = 1'b0;
        reqs.push_back(mk_req(1'b0, 16'h0004, 32'h0));
        run_until_mem("t7_first", 1, 20);
        repeat (3) tick();
        netout_if.rdy = 1'b0;
        reqs.push_back(mk_req(1'b0, 16'h0004, 32'h0));
        repeat (3) tick();
        chk("t7_req_full", netout_if.val, 1'b1);
        chk("t7_resp_full", memresp_if.val, 1'b1);
        reset = 1'b1;
        tick();
        chk("t7_netout_val", netout_if.val, 1'b0);
        chk("t7_memresp_val", memresp_if.val, 1'b0);
        chk("t7_err", err, 1'b0);
        reset = 1'b0;
        reqs.delete(); mem_q.delete();
        netin_if.val = 1'b0;
        netout_if.rdy = 1'b1; memresp_if.rdy = 1'b1;
        memreq_if.msg = mk_req(1'b0, 16'h0008, 32'h0);
        memreq_if.val = 1'b1;
        #1;
        chk("t7_admit", memreq_if.rdy, 1'b1);
        run_until_idle("t7_idle", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
